// File: rtl/saes_cipher_core_if.sv
// saes_cipher_core_if: request/result bundle for the S-AES cipher core.
// Optional decrypt control appears only when SAES_DECRYPT_EN is defined.
//
// Handshake: the master raises start with din/k0/k1/k2 (and decrypt) valid.
// The core samples them only while idle, raises busy for the next two cycles,
// then pulses done for exactly one cycle with dout valid. dout holds until
// the next done. start seen while busy is dropped, not queued.
interface saes_cipher_core_if;
  logic        start;
  logic [15:0] din;
  logic [15:0] k0;
  logic [15:0] k1;
  logic [15:0] k2;
`ifdef SAES_DECRYPT_EN
  logic        decrypt;
`endif
  logic [15:0] dout;
  logic        busy;
  logic        done;
  logic [1:0]  fsm_state;

`ifdef SAES_DECRYPT_EN
  modport master (output start, din, k0, k1, k2, decrypt,
                  input  dout, busy, done, fsm_state);
  modport slave  (input  start, din, k0, k1, k2, decrypt,
                  output dout, busy, done, fsm_state);
`else
  modport master (output start, din, k0, k1, k2,
                  input  dout, busy, done, fsm_state);
  modport slave  (input  start, din, k0, k1, k2,
                  output dout, busy, done, fsm_state);
`endif
endinterface

// File: rtl/saes_cipher_core.sv
// saes_cipher_core: iterative 16-bit simplified-AES datapath, one round per
// clock, start/busy/done handshake. Define SAES_DECRYPT_EN to add the
// decrypt port and the inverse datapath; the default build is encrypt-only.
module saes_cipher_core (
  input  logic               clk,
  input  logic               nrst,
  saes_cipher_core_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RND1 = 2'd1,
    RND2 = 2'd2
  } state_t;

  state_t      state, next_state;
  logic [15:0] st, st_d;
  logic [15:0] k1_lat, k1_d;
  // Key used in the final round: k2 for encrypt, k0 for decrypt.
  logic [15:0] klast_lat, klast_d;
  logic [15:0] dout_r, dout_d;
  logic        busy_r, busy_d;
  logic        done_r, done_d;
  logic [15:0] enc_r1, enc_r2;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'h9;  4'h1: sbox = 4'h4;  4'h2: sbox = 4'hA;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'hD;  4'h5: sbox = 4'h1;  4'h6: sbox = 4'h8;  4'h7: sbox = 4'h5;
      4'h8: sbox = 4'h6;  4'h9: sbox = 4'h2;  4'hA: sbox = 4'h0;  4'hB: sbox = 4'h3;
      4'hC: sbox = 4'hC;  4'hD: sbox = 4'hE;  4'hE: sbox = 4'hF;  default: sbox = 4'h7;
    endcase
  endfunction

  function automatic logic [15:0] nib_sub(input logic [15:0] x);
    nib_sub = {sbox(x[15:12]), sbox(x[11:8]), sbox(x[7:4]), sbox(x[3:0])};
  endfunction

  // ShiftRows on a 2x2 state only exchanges s1 and s3.
  function automatic logic [15:0] shift_rows(input logic [15:0] x);
    shift_rows = {x[15:12], x[3:0], x[7:4], x[11:8]};
  endfunction

  // Multiply by x in GF(2^4) modulo x^4+x+1.
  function automatic logic [3:0] gf_x2(input logic [3:0] a);
    gf_x2 = {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [3:0] gf_x4(input logic [3:0] a);
    gf_x4 = gf_x2(gf_x2(a));
  endfunction

  function automatic logic [15:0] mix_cols(input logic [15:0] x);
    mix_cols = {x[15:12] ^ gf_x4(x[11:8]), gf_x4(x[15:12]) ^ x[11:8],
                x[7:4]   ^ gf_x4(x[3:0]),  gf_x4(x[7:4])   ^ x[3:0]};
  endfunction

  assign enc_r1 = mix_cols(shift_rows(nib_sub(st))) ^ k1_lat;
  assign enc_r2 = shift_rows(nib_sub(st)) ^ klast_lat;

`ifdef SAES_DECRYPT_EN
  logic        dec_lat, dec_d;
  logic [15:0] dec_r1, dec_r2;

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: inv_sbox = 4'hA;  4'h1: inv_sbox = 4'h5;  4'h2: inv_sbox = 4'h9;  4'h3: inv_sbox = 4'hB;
      4'h4: inv_sbox = 4'h1;  4'h5: inv_sbox = 4'h7;  4'h6: inv_sbox = 4'h8;  4'h7: inv_sbox = 4'hF;
      4'h8: inv_sbox = 4'h6;  4'h9: inv_sbox = 4'h0;  4'hA: inv_sbox = 4'h2;  4'hB: inv_sbox = 4'h3;
      4'hC: inv_sbox = 4'hC;  4'hD: inv_sbox = 4'h4;  4'hE: inv_sbox = 4'hD;  default: inv_sbox = 4'hE;
    endcase
  endfunction

  function automatic logic [15:0] inv_nib_sub(input logic [15:0] x);
    inv_nib_sub = {inv_sbox(x[15:12]), inv_sbox(x[11:8]), inv_sbox(x[7:4]), inv_sbox(x[3:0])};
  endfunction

  // 9*a = 8*a ^ a
  function automatic logic [3:0] gf_x9(input logic [3:0] a);
    gf_x9 = gf_x2(gf_x4(a)) ^ a;
  endfunction

  function automatic logic [15:0] inv_mix_cols(input logic [15:0] x);
    inv_mix_cols = {gf_x9(x[15:12]) ^ gf_x2(x[11:8]), gf_x2(x[15:12]) ^ gf_x9(x[11:8]),
                    gf_x9(x[7:4])   ^ gf_x2(x[3:0]),  gf_x2(x[7:4])   ^ gf_x9(x[3:0])};
  endfunction

  assign dec_r1 = inv_mix_cols(inv_nib_sub(shift_rows(st)) ^ k1_lat);
  assign dec_r2 = inv_nib_sub(shift_rows(st)) ^ klast_lat;

  // Direction flag captured at acceptance and held for the transaction.
  always_ff @(posedge clk) begin
    if (!nrst) dec_lat <= 1'b0;
    else       dec_lat <= dec_d;
  end
`endif

  // Next-state and datapath updates; every target defaults to holding.
  always_comb begin
    next_state = state;
    st_d       = st;
    k1_d       = k1_lat;
    klast_d    = klast_lat;
    dout_d     = dout_r;
    busy_d     = busy_r;
    done_d     = 1'b0;
`ifdef SAES_DECRYPT_EN
    dec_d      = dec_lat;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
`ifdef SAES_DECRYPT_EN
          dec_d   = bus.decrypt;
          st_d    = bus.din ^ (bus.decrypt ? bus.k2 : bus.k0);
          klast_d = bus.decrypt ? bus.k0 : bus.k2;
`else
          st_d    = bus.din ^ bus.k0;
          klast_d = bus.k2;
`endif
          k1_d       = bus.k1;
          busy_d     = 1'b1;
          next_state = RND1;
        end
      end
      RND1: begin
`ifdef SAES_DECRYPT_EN
        st_d = dec_lat ? dec_r1 : enc_r1;
`else
        st_d = enc_r1;
`endif
        next_state = RND2;
      end
      RND2: begin
`ifdef SAES_DECRYPT_EN
        dout_d = dec_lat ? dec_r2 : enc_r2;
`else
        dout_d = enc_r2;
`endif
        done_d     = 1'b1;
        busy_d     = 1'b0;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State, datapath and output registers; reset aborts any transaction.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= IDLE;
      st        <= 16'h0000;
      k1_lat    <= 16'h0000;
      klast_lat <= 16'h0000;
      dout_r    <= 16'h0000;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state     <= next_state;
      st        <= st_d;
      k1_lat    <= k1_d;
      klast_lat <= klast_d;
      dout_r    <= dout_d;
      busy_r    <= busy_d;
      done_r    <= done_d;
    end
  end

  assign bus.dout      = dout_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_saes_cipher_core.sv
// tb_saes_cipher_core: directed known-answer bench for saes_cipher_core with
// a transaction-level S-AES reference model. Build with SAES_DECRYPT_EN to
// also exercise decryption.
module tb_saes_cipher_core;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  saes_cipher_core_if bus ();

  saes_cipher_core dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // ---------------- reference model ----------------
  logic [3:0] sbox_t [16] = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
                              4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};
  logic [3:0] isbox_t[16] = '{4'hA, 4'h5, 4'h9, 4'hB, 4'h1, 4'h7, 4'h8, 4'hF,
                              4'h6, 4'h0, 4'h2, 4'h3, 4'hC, 4'h4, 4'hD, 4'hE};

  // Generic shift-and-add GF(2^4) multiply, polynomial x^4+x+1.
  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] aa;
    logic [3:0] p;
    aa = {1'b0, a};
    p  = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ aa[3:0];
      aa = aa << 1;
      if (aa[4]) aa = aa ^ 5'h13;
    end
    return p;
  endfunction

  function automatic logic [15:0] m_sub(input logic [15:0] x, input bit inv);
    logic [15:0] r;
    for (int i = 0; i < 4; i++)
      r[i*4 +: 4] = inv ? isbox_t[x[i*4 +: 4]] : sbox_t[x[i*4 +: 4]];
    return r;
  endfunction

  function automatic logic [15:0] m_shift(input logic [15:0] x);
    logic [3:0] n [4];
    for (int i = 0; i < 4; i++) n[i] = x[15 - 4*i -: 4];
    return {n[0], n[3], n[2], n[1]};
  endfunction

  // Column times matrix [[d, o], [o, d]].
  function automatic logic [15:0] m_mix(input logic [15:0] x, input logic [3:0] d, input logic [3:0] o);
    logic [15:0] r;
    for (int c = 0; c < 2; c++) begin
      logic [3:0] a, b;
      a = x[15 - 8*c -: 4];
      b = x[11 - 8*c -: 4];
      r[15 - 8*c -: 4] = gmul(d, a) ^ gmul(o, b);
      r[11 - 8*c -: 4] = gmul(o, a) ^ gmul(d, b);
    end
    return r;
  endfunction

  function automatic logic [15:0] model_enc(input logic [15:0] d, k0, k1, k2);
    logic [15:0] s;
    s = d ^ k0;
    s = m_mix(m_shift(m_sub(s, 1'b0)), 4'h1, 4'h4) ^ k1;
    s = m_shift(m_sub(s, 1'b0)) ^ k2;
    return s;
  endfunction

  function automatic logic [15:0] model_dec(input logic [15:0] d, k0, k1, k2);
    logic [15:0] s;
    s = d ^ k2;
    s = m_mix(m_sub(m_shift(s), 1'b1) ^ k1, 4'h9, 4'h2);
    s = m_sub(m_shift(s), 1'b1) ^ k0;
    return s;
  endfunction

  // Cycle behaviour: accepted request -> result two edges later on done.
  logic [15:0] exp_q[$];
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [15:0] m_dout = 16'h0000;
  int          m_left = 0;

  always @(posedge clk) begin
    if (!nrst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dout <= 16'h0000;
      m_left <= 0;
      exp_q.delete();
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (bus.start) begin
`ifdef SAES_DECRYPT_EN
          exp_q.push_back(bus.decrypt ? model_dec(bus.din, bus.k0, bus.k1, bus.k2)
                                      : model_enc(bus.din, bus.k0, bus.k1, bus.k2));
`else
          exp_q.push_back(model_enc(bus.din, bus.k0, bus.k1, bus.k2));
`endif
          m_left <= 2;
          m_busy <= 1'b1;
        end
      end else if (m_left == 2) begin
        m_left <= 1;
      end else begin
        if (exp_q.size() > 0) m_dout <= exp_q.pop_front();
        m_done <= 1'b1;
        m_busy <= 1'b0;
        m_left <= 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", {15'd0, bus.busy}, {15'd0, m_busy});
      chk("cyc_done", {15'd0, bus.done}, {15'd0, m_done});
      chk("cyc_dout", bus.dout, m_dout);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_start(input logic [15:0] d, a, b, c, input bit dec);
    bus.din   = d;
    bus.k0    = a;
    bus.k1    = b;
    bus.k2    = c;
`ifdef SAES_DECRYPT_EN
    bus.decrypt = dec;
`else
    if (dec) $display("decrypt request ignored in encrypt-only build");
`endif
    bus.start = 1'b1;
  endtask

  // Start at the current negedge, then check the three following cycles.
  task automatic run_txn(input string nm, input logic [15:0] d, a, b, c,
                         input bit dec, input logic [15:0] exp);
    drive_start(d, a, b, c, dec);
    @(negedge clk);
    bus.start = 1'b0;
    chk({nm, "_busy1"}, {15'd0, bus.busy}, 16'd1);
    chk({nm, "_done1"}, {15'd0, bus.done}, 16'd0);
    @(negedge clk);
    chk({nm, "_busy2"}, {15'd0, bus.busy}, 16'd1);
    chk({nm, "_done2"}, {15'd0, bus.done}, 16'd0);
    @(negedge clk);
    chk({nm, "_done"}, {15'd0, bus.done}, 16'd1);
    chk({nm, "_busy3"}, {15'd0, bus.busy}, 16'd0);
    chk({nm, "_dout"}, bus.dout, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start = 1'b1;
    bus.din   = 16'h0000;
    bus.k0    = 16'h0000;
    bus.k1    = 16'h0000;
    bus.k2    = 16'h0000;
`ifdef SAES_DECRYPT_EN
    bus.decrypt = 1'b0;
`endif

    // Pin the model with hand-computed answers.
    chk("model_kat", model_enc(16'h6F6B, 16'hA73B, 16'h1C27, 16'h7651), 16'h0738);
    chk("model_b2b", model_enc(16'hD728, 16'h4AF5, 16'hDD28, 16'h87AF), 16'h24EC);
    chk("model_dec", model_dec(16'h0738, 16'hA73B, 16'h1C27, 16'h7651), 16'h6F6B);

    // Reset held for two edges with start high.
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_dout", bus.dout, 16'h0000);
    chk("rst_busy", {15'd0, bus.busy}, 16'd0);
    chk("rst_done", {15'd0, bus.done}, 16'd0);
    nrst = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("idle_busy", {15'd0, bus.busy}, 16'd0);

    // Known-answer encrypt.
    run_txn("kat", 16'h6F6B, 16'hA73B, 16'h1C27, 16'h7651, 1'b0, 16'h0738);

    // Back-to-back start in the done cycle; first result holds meanwhile.
    drive_start(16'hD728, 16'h4AF5, 16'hDD28, 16'h87AF, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_hold1", bus.dout, 16'h0738);
    chk("b2b_busy1", {15'd0, bus.busy}, 16'd1);
    @(negedge clk);
    chk("b2b_hold2", bus.dout, 16'h0738);
    chk("b2b_done2", {15'd0, bus.done}, 16'd0);
    @(negedge clk);
    chk("b2b_done", {15'd0, bus.done}, 16'd1);
    chk("b2b_dout", bus.dout, 16'h24EC);
    @(negedge clk);
    chk("done_clear", {15'd0, bus.done}, 16'd0);

    // Start and inputs changed during RND1 are ignored.
    drive_start(16'h6F6B, 16'hA73B, 16'h1C27, 16'h7651, 1'b0);
    @(negedge clk);
    drive_start(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("ign_done", {15'd0, bus.done}, 16'd1);
    chk("ign_dout", bus.dout, 16'h0738);
    @(negedge clk);
    chk("ign_no_extra_busy", {15'd0, bus.busy}, 16'd0);
    chk("ign_single_done", {15'd0, bus.done}, 16'd0);
    @(negedge clk);
    chk("ign_still_idle", {15'd0, bus.busy}, 16'd0);

    // Reset during RND2 aborts without a done pulse.
    drive_start(16'h6F6B, 16'hA73B, 16'h1C27, 16'h7651, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    chk("abort_done", {15'd0, bus.done}, 16'd0);
    chk("abort_dout", bus.dout, 16'h0000);
    chk("abort_busy", {15'd0, bus.busy}, 16'd0);
    nrst = 1'b1;
    @(negedge clk);
    chk("abort_no_late_done", {15'd0, bus.done}, 16'd0);
    run_txn("fresh", 16'h6F6B, 16'hA73B, 16'h1C27, 16'h7651, 1'b0, 16'h0738);

`ifdef SAES_DECRYPT_EN
    @(negedge clk);
    run_txn("dec", 16'h0738, 16'hA73B, 16'h1C27, 16'h7651, 1'b1, 16'h6F6B);
    run_txn("enc_after_dec", 16'h6F6B, 16'hA73B, 16'h1C27, 16'h7651, 1'b0, 16'h0738);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
